// File: rtl/ballot_collector.sv
// Serial vote collector for the 4-voter majority tally: gathers one vote per voter,
// rejects duplicates, and forces the ballot out after a collection timeout.
module ballot_collector #(
  parameter int TIMEOUT_CYC = 16,
  parameter int TW          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       vote_valid,
  input  logic [1:0] vote_id,
  input  logic       vote_val,
  output logic       vote_ready,
  output logic [3:0] ballot,
  output logic       ballot_valid,
  input  logic       ballot_ready,
  output logic [3:0] voted_mask,
  output logic       busy,
  output logic       dup_err,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic [3:0]    id_onehot;
  logic          accept;
  logic          is_dup;
  logic          new_vote;
  logic [3:0]    mask_after;
  logic          at_limit;
  logic          timed_out;

  assign id_onehot  = 4'b0001 << vote_id;
  assign accept     = (state == COLLECT) && vote_valid;
  assign is_dup     = accept && ((voted_mask & id_onehot) != 4'b0000);
  assign new_vote   = accept && !is_dup;
  assign mask_after = new_vote ? (voted_mask | id_onehot) : voted_mask;
  assign at_limit   = (timer == TW'(TIMEOUT_CYC - 1));

  assign vote_ready   = (state == COLLECT);
  assign ballot_valid = (state == PRESENT);
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A vote that completes the mask wins over the timeout in the same cycle.
  always_comb begin
    state_next = state;
    timed_out  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (mask_after == 4'b1111) begin
          state_next = PRESENT;
        end else if (at_limit) begin
          state_next = PRESENT;
          timed_out  = 1'b1;
        end
      end
      PRESENT: begin
        if (ballot_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ballot and mask survive the return to IDLE and are only cleared by the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ballot     <= 4'b0000;
      voted_mask <= 4'b0000;
      timer      <= '0;
      dup_err    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      dup_err <= is_dup;
      timeout <= timed_out;
      case (state)
        IDLE: begin
          if (start) begin
            ballot     <= 4'b0000;
            voted_mask <= 4'b0000;
            timer      <= '0;
          end
        end
        COLLECT: begin
          timer <= timer + TW'(1);
          if (new_vote) begin
            ballot[vote_id] <= vote_val;
            voted_mask      <= mask_after;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector: a round-level model checked every cycle,
// plus literal expectations for each scenario.
module tb_ballot_collector;

  localparam int TIMEOUT_CYC = 16;
  localparam int TW          = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       vote_valid;
  logic [1:0] vote_id;
  logic       vote_val;
  logic       vote_ready;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic       ballot_ready;
  logic [3:0] voted_mask;
  logic       busy;
  logic       dup_err;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ballot_collector #(.TIMEOUT_CYC(TIMEOUT_CYC), .TW(TW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vote_valid   (vote_valid),
    .vote_id      (vote_id),
    .vote_val     (vote_val),
    .vote_ready   (vote_ready),
    .ballot       (ballot),
    .ballot_valid (ballot_valid),
    .ballot_ready (ballot_ready),
    .voted_mask   (voted_mask),
    .busy         (busy),
    .dup_err      (dup_err),
    .timeout      (timeout)
  );

  // Round model: phase 0 = waiting, 1 = collecting, 2 = presenting.
  int m_phase   = 0;
  int m_elapsed = 0;
  bit m_voted[4];
  bit m_yes[4];
  bit m_dup     = 1'b0;
  bit m_to      = 1'b0;

  function automatic int votes_cast();
    int n = 0;
    for (int i = 0; i < 4; i++) n += m_voted[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [3:0] model_ballot();
    logic [3:0] b = 4'b0000;
    for (int i = 0; i < 4; i++) b[i] = m_voted[i] & m_yes[i];
    return b;
  endfunction

  function automatic logic [3:0] model_mask();
    logic [3:0] m = 4'b0000;
    for (int i = 0; i < 4; i++) m[i] = m_voted[i];
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit dup_now;
    bit to_now;
    if (!rst_n) begin
      m_phase   = 0;
      m_elapsed = 0;
      m_dup     = 1'b0;
      m_to      = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_voted[i] = 1'b0;
        m_yes[i]   = 1'b0;
      end
    end else begin
      dup_now = 1'b0;
      to_now  = 1'b0;
      case (m_phase)
        0: if (start) begin
          for (int i = 0; i < 4; i++) begin
            m_voted[i] = 1'b0;
            m_yes[i]   = 1'b0;
          end
          m_elapsed = 0;
          m_phase   = 1;
        end
        1: begin
          if (vote_valid) begin
            if (m_voted[vote_id]) dup_now = 1'b1;
            else begin
              m_voted[vote_id] = 1'b1;
              m_yes[vote_id]   = vote_val;
            end
          end
          m_elapsed++;
          if (votes_cast() == 4) m_phase = 2;
          else if (m_elapsed == TIMEOUT_CYC) begin
            m_phase = 2;
            to_now  = 1'b1;
          end
        end
        default: if (ballot_ready) m_phase = 0;
      endcase
      m_dup = dup_now;
      m_to  = to_now;
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs right after a falling edge; return at the next falling edge.
  task automatic applyStimulus(input logic s, input logic vv, input logic [1:0] id,
                               input logic val, input logic br);
    start        = s;
    vote_valid   = vv;
    vote_id      = id;
    vote_val     = val;
    ballot_ready = br;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("vote_ready",   8'(vote_ready),   8'(m_phase == 1));
      checkOutput("ballot_valid", 8'(ballot_valid), 8'(m_phase == 2));
      checkOutput("busy",         8'(busy),         8'(m_phase != 0));
      checkOutput("ballot",       8'(ballot),       8'(model_ballot()));
      checkOutput("voted_mask",   8'(voted_mask),   8'(model_mask()));
      checkOutput("dup_err",      8'(dup_err),      8'(m_dup));
      checkOutput("timeout",      8'(timeout),      8'(m_to));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0; vote_valid = 1'b0; vote_id = 2'd0; vote_val = 1'b0; ballot_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ballot",       8'(ballot),       8'h0);
    checkOutput("rst_mask",         8'(voted_mask),   8'h0);
    checkOutput("rst_vote_ready",   8'(vote_ready),   8'h0);
    checkOutput("rst_ballot_valid", 8'(ballot_valid), 8'h0);
    checkOutput("rst_busy",         8'(busy),         8'h0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] test 1: full round");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("t1_busy", 8'(busy), 8'h1);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 2, 0, 0);
    applyStimulus(0, 1, 3, 1, 0);
    checkOutput("t1_valid",   8'(ballot_valid), 8'h1);
    checkOutput("t1_ballot",  8'(ballot),       8'b1011);
    checkOutput("t1_mask",    8'(voted_mask),   8'b1111);
    checkOutput("t1_timeout", 8'(timeout),      8'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t1_idle_busy",   8'(busy),   8'h0);
    checkOutput("t1_idle_ballot", 8'(ballot), 8'b1011);

    $display("[TB] test 2: duplicate vote");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 2, 1, 0);
    applyStimulus(0, 1, 2, 0, 0);
    checkOutput("t2_dup_pulse", 8'(dup_err), 8'h1);
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("t2_dup_clear", 8'(dup_err), 8'h0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 3, 0, 0);
    checkOutput("t2_ballot", 8'(ballot), 8'b0101);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] test 3: timeout with one vote");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 3, 1, 0);
    n = 1;
    while (ballot_valid !== 1'b1 && n < 40) begin
      applyStimulus(0, 0, 0, 0, 0);
      n++;
    end
    checkOutput("t3_collect_cycles", 8'(n), 8'd16);
    checkOutput("t3_ballot",  8'(ballot),     8'b1000);
    checkOutput("t3_mask",    8'(voted_mask), 8'b1000);
    checkOutput("t3_timeout", 8'(timeout),    8'h1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t3_timeout_pulse", 8'(timeout), 8'h0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] test 4: last vote on the timeout cycle");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 2, 1, 0);
    repeat (12) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("t4_still_collect", 8'(ballot_valid), 8'h0);
    applyStimulus(0, 1, 3, 1, 0);
    checkOutput("t4_valid",   8'(ballot_valid), 8'h1);
    checkOutput("t4_ballot",  8'(ballot),       8'b1101);
    checkOutput("t4_mask",    8'(voted_mask),   8'b1111);
    checkOutput("t4_timeout", 8'(timeout),      8'h0);
    applyStimulus(0, 0, 0, 0, 1);

    $display("[TB] test 5: ballot held while downstream stalls");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 2, 1, 0);
    applyStimulus(0, 1, 3, 0, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(i[0], ~i[0], 2'(i), i[1], 0);
      checkOutput("t5_valid",      8'(ballot_valid), 8'h1);
      checkOutput("t5_vote_ready", 8'(vote_ready),   8'h0);
      checkOutput("t5_ballot",     8'(ballot),       8'b0110);
    end
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("t5_idle_after_ready", 8'(busy), 8'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("t5_ready_in_idle", 8'(busy), 8'h0);

    $display("[TB] test 6: asynchronous reset mid-round");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0);
    applyStimulus(0, 1, 1, 1, 0);
    vote_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_ballot",       8'(ballot),       8'h0);
    checkOutput("t6_mask",         8'(voted_mask),   8'h0);
    checkOutput("t6_vote_ready",   8'(vote_ready),   8'h0);
    checkOutput("t6_ballot_valid", 8'(ballot_valid), 8'h0);
    checkOutput("t6_busy",         8'(busy),         8'h0);
    checkOutput("t6_dup_err",      8'(dup_err),      8'h0);
    checkOutput("t6_timeout",      8'(timeout),      8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0);
    applyStimulus(0, 1, 2, 1, 0);
    applyStimulus(0, 1, 3, 0, 0);
    checkOutput("t6_new_valid",  8'(ballot_valid), 8'h1);
    checkOutput("t6_new_ballot", 8'(ballot),       8'b0110);
    checkOutput("t6_new_mask",   8'(voted_mask),   8'b1111);
    applyStimulus(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
